// File: rtl/rpn_calc_ext.sv
// rpn_calc_ext: RPN stack calculator, top of stack in a register, body in RAM.
// Define RPN_CALC_MUL_EN to build MUL as an N-cycle iterative shift-add unit.
module rpn_calc_ext #(
    parameter int N = 16,
    parameter int M = 10
) (
    input  logic         step,
    input  logic         nrst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         push,
    input  logic [2:0]   op,
    input  logic [N-1:0] d,
    input  logic         err_clr,
    output logic [N-1:0] out,
    output logic [M-1:0] cnt,
    output logic         err_ovf,
    output logic         err_unf,
    output logic         err_ill
);
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_NEG  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_DUP  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_DROP = 3'd7;

    localparam logic [M-1:0] ONE  = M'(1);
    localparam logic [M-1:0] FULL = '1;

    logic [N-1:0] top_q, top_d;
    logic [M-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic         ill_q, ill_d;

    // Slot k holds the element that was on top when the count was k.
    logic [N-1:0] mem [2**M];
    logic         mem_we;
    logic [M-1:0] mem_wa;
    logic [N-1:0] mem_wd;
    logic [N-1:0] second;

    logic accept;
    logic has1;
    logic has2;
    logic full;
    logic set_ovf;
    logic set_unf;
    logic set_ill;

    assign second = mem[cnt_q - ONE];
    assign has1   = (cnt_q != '0);
    assign has2   = (cnt_q > ONE);
    assign full   = (cnt_q == FULL);
    assign accept = in_valid && in_ready;

`ifdef RPN_CALC_MUL_EN
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic [N-1:0]  acc_step;
    logic          mul_go;
    logic          mul_done;

    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign mul_done = (state_q == S_MUL) && (ctr_q == LAST);
    assign in_ready = (state_q == S_IDLE);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        ctr_d    = ctr_q;
        if (state_q == S_MUL) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            ctr_d    = ctr_q + CW'(1);
            if (mul_done) begin
                state_d = S_IDLE;
            end
        end else if (mul_go) begin
            state_d  = S_MUL;
            mcand_d  = second;
            mplier_d = top_q;
            acc_d    = '0;
            ctr_d    = '0;
        end
    end

    always_ff @(posedge step or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            ctr_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            ctr_q    <= ctr_d;
        end
    end
`else
    assign in_ready = 1'b1;
`endif

    always_comb begin
        top_d   = top_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_wa  = cnt_q;
        mem_wd  = top_q;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_ill = 1'b0;
`ifdef RPN_CALC_MUL_EN
        mul_go  = 1'b0;
`endif
        if (accept) begin
            if (push) begin
                if (full) begin
                    set_ovf = 1'b1;
                end else begin
                    top_d  = d;
                    cnt_d  = cnt_q + ONE;
                    mem_we = 1'b1;
                end
            end else begin
                unique case (op)
                    OP_NOP: begin
                    end
                    OP_NEG: begin
                        if (has1) top_d = -top_q;
                        else set_unf = 1'b1;
                    end
                    OP_ADD: begin
                        if (has2) begin
                            top_d = second + top_q;
                            cnt_d = cnt_q - ONE;
                        end else begin
                            set_unf = 1'b1;
                        end
                    end
                    OP_SUB: begin
                        if (has2) begin
                            top_d = second - top_q;
                            cnt_d = cnt_q - ONE;
                        end else begin
                            set_unf = 1'b1;
                        end
                    end
                    OP_MUL: begin
`ifdef RPN_CALC_MUL_EN
                        if (has2) mul_go = 1'b1;
                        else set_unf = 1'b1;
`else
                        set_ill = 1'b1;
`endif
                    end
                    OP_DUP: begin
                        if (!has1) begin
                            set_unf = 1'b1;
                        end else if (full) begin
                            set_ovf = 1'b1;
                        end else begin
                            cnt_d  = cnt_q + ONE;
                            mem_we = 1'b1;
                        end
                    end
                    OP_SWAP: begin
                        if (has2) begin
                            top_d  = second;
                            mem_we = 1'b1;
                            mem_wa = cnt_q - ONE;
                        end else begin
                            set_unf = 1'b1;
                        end
                    end
                    OP_DROP: begin
                        if (has1) begin
                            top_d = has2 ? second : '0;
                            cnt_d = cnt_q - ONE;
                        end else begin
                            set_unf = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
`ifdef RPN_CALC_MUL_EN
        // Product and shrunken count land together on the last iteration.
        if (mul_done) begin
            top_d = acc_step;
            cnt_d = cnt_q - ONE;
        end
`endif
        ovf_d = set_ovf || (ovf_q && !err_clr);
        unf_d = set_unf || (unf_q && !err_clr);
        ill_d = set_ill || (ill_q && !err_clr);
    end

    always_ff @(posedge step or negedge nrst) begin
        if (!nrst) begin
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            ill_q <= ill_d;
        end
    end

    always_ff @(posedge step) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign out     = top_q;
    assign cnt     = cnt_q;
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
    assign err_ill = ill_q;

endmodule

// File: tb/tb_rpn_calc_ext.sv
// tb_rpn_calc_ext: directed scoreboard bench for rpn_calc_ext at N=8, M=3.
// MUL checks follow whether RPN_CALC_MUL_EN is defined for the build.
module tb_rpn_calc_ext;
    localparam int N = 8;
    localparam int M = 3;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] NEG  = 3'd1;
    localparam logic [2:0] ADD  = 3'd2;
    localparam logic [2:0] SUB  = 3'd3;
    localparam logic [2:0] MUL  = 3'd4;
    localparam logic [2:0] DUP  = 3'd5;
    localparam logic [2:0] SWAP = 3'd6;
    localparam logic [2:0] DROP = 3'd7;

    logic         step = 1'b0;
    logic         nrst = 1'b1;
    logic         in_valid = 1'b0;
    logic         push = 1'b0;
    logic         err_clr = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [N-1:0] d = '0;
    logic         in_ready;
    logic [N-1:0] out;
    logic [M-1:0] cnt;
    logic         err_ovf;
    logic         err_unf;
    logic         err_ill;

    typedef struct {
        string        tag;
        logic [N-1:0] o;
        logic [M-1:0] c;
        logic [2:0]   f;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lows;

    always #5 step = ~step;

    rpn_calc_ext #(.N(N), .M(M)) dut (
        .step    (step),
        .nrst    (nrst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .push    (push),
        .op      (op),
        .d       (d),
        .err_clr (err_clr),
        .out     (out),
        .cnt     (cnt),
        .err_ovf (err_ovf),
        .err_unf (err_unf),
        .err_ill (err_ill)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic expect_state(input string tag, input logic [N-1:0] eo,
                                input logic [M-1:0] ec, input logic [2:0] ef);
        exp_t e;
        e.tag = tag;
        e.o   = eo;
        e.c   = ec;
        e.f   = ef;
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "/out"}, 32'(out), 32'(e.o));
        chk({e.tag, "/cnt"}, 32'(cnt), 32'(e.c));
        chk({e.tag, "/flags"}, 32'({err_ovf, err_unf, err_ill}), 32'(e.f));
        chk({e.tag, "/ready"}, 32'(in_ready), 32'd1);
    endtask

    // One accepted command; caller may pre-set err_clr for the same edge.
    task automatic cmd(input string tag, input logic p, input logic [2:0] o,
                       input logic [N-1:0] dv, input logic [N-1:0] eo,
                       input logic [M-1:0] ec, input logic [2:0] ef);
        expect_state(tag, eo, ec, ef);
        in_valid = 1'b1;
        push     = p;
        op       = o;
        d        = dv;
        @(posedge step);
        #1;
        in_valid = 1'b0;
        push     = 1'b0;
        err_clr  = 1'b0;
        pop_chk();
    endtask

    task automatic clr(input string tag);
        err_clr = 1'b1;
        @(posedge step);
        #1;
        err_clr = 1'b0;
        chk({tag, "/clr"}, 32'({err_ovf, err_unf, err_ill}), 32'd0);
    endtask

    initial begin
        #1 nrst = 1'b0;
        #2;
        chk("rst/out", 32'(out), 32'd0);
        chk("rst/cnt", 32'(cnt), 32'd0);
        chk("rst/ready", 32'(in_ready), 32'd1);
        chk("rst/flags", 32'({err_ovf, err_unf, err_ill}), 32'd0);
        @(posedge step);
        #1 nrst = 1'b1;

        cmd("push3", 1, NOP, 8'd3, 8'd3, 3'd1, 3'b000);
        cmd("push4", 1, NOP, 8'd4, 8'd4, 3'd2, 3'b000);
        cmd("add", 0, ADD, 8'd0, 8'd7, 3'd1, 3'b000);
        cmd("drop1", 0, DROP, 8'd0, 8'd0, 3'd0, 3'b000);
        cmd("drop_empty", 0, DROP, 8'd0, 8'd0, 3'd0, 3'b010);
        clr("unf0");

        cmd("push5", 1, NOP, 8'd5, 8'd5, 3'd1, 3'b000);
        cmd("push2", 1, NOP, 8'd2, 8'd2, 3'd2, 3'b000);
        cmd("sub", 0, SUB, 8'd0, 8'd3, 3'd1, 3'b000);
        cmd("neg", 0, NEG, 8'd0, 8'hFD, 3'd1, 3'b000);
        cmd("swap_unf", 0, SWAP, 8'd0, 8'hFD, 3'd1, 3'b010);
        clr("unf1");

        cmd("push10", 1, NOP, 8'h10, 8'h10, 3'd2, 3'b000);
        cmd("swap", 0, SWAP, 8'd0, 8'hFD, 3'd2, 3'b000);
        cmd("drop2", 0, DROP, 8'd0, 8'h10, 3'd1, 3'b000);
        cmd("dup", 0, DUP, 8'd0, 8'h10, 3'd2, 3'b000);
        cmd("add2", 0, ADD, 8'd0, 8'h20, 3'd1, 3'b000);
        cmd("nop", 0, NOP, 8'h77, 8'h20, 3'd1, 3'b000);
        cmd("push_over_op", 1, ADD, 8'h33, 8'h33, 3'd2, 3'b000);
        cmd("drop3", 0, DROP, 8'd0, 8'h20, 3'd1, 3'b000);
        cmd("drop4", 0, DROP, 8'd0, 8'h00, 3'd0, 3'b000);
        cmd("neg_empty", 0, NEG, 8'd0, 8'h00, 3'd0, 3'b010);
        clr("unf2");

        for (int i = 1; i <= 7; i++) begin
            cmd($sformatf("fill%0d", i), 1, NOP, 8'(i), 8'(i), 3'(i), 3'b000);
        end
        cmd("push_full", 1, NOP, 8'd8, 8'd7, 3'd7, 3'b100);
        clr("ovf0");
        err_clr = 1'b1;
        cmd("dup_full_clr", 0, DUP, 8'd0, 8'd7, 3'd7, 3'b100);
        clr("ovf1");
        for (int i = 7; i >= 1; i--) begin
            cmd($sformatf("unfill%0d", i), 0, DROP, 8'd0,
                8'(i - 1), 3'(i - 1), 3'b000);
        end

`ifdef RPN_CALC_MUL_EN
        cmd("mpush_a", 1, NOP, 8'd20, 8'd20, 3'd1, 3'b000);
        cmd("mpush_b", 1, NOP, 8'd20, 8'd20, 3'd2, 3'b000);
        expect_state("mul", 8'd144, 3'd1, 3'b000);
        in_valid = 1'b1;
        op       = MUL;
        @(posedge step);
        #1;
        in_valid = 1'b0;
        lows = 0;
        while (!in_ready && lows < 20) begin
            lows++;
            if (lows == 2) begin
                in_valid = 1'b1;
                push     = 1'b1;
                d        = 8'h55;
            end
            if (lows == 3) begin
                in_valid = 1'b0;
                push     = 1'b0;
            end
            if (lows == 4) begin
                chk("mul_busy/out", 32'(out), 32'd20);
                chk("mul_busy/cnt", 32'(cnt), 32'd2);
            end
            @(posedge step);
            #1;
        end
        chk("mul_latency", 32'(lows), 32'd8);
        pop_chk();
        cmd("mul_unf", 0, MUL, 8'd0, 8'd144, 3'd1, 3'b010);
        clr("unf3");

        cmd("mpush_c", 1, NOP, 8'd20, 8'd20, 3'd2, 3'b000);
        in_valid = 1'b1;
        op       = MUL;
        @(posedge step);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge step);
        #3 nrst = 1'b0;
        #1;
        chk("mul_rst/out", 32'(out), 32'd0);
        chk("mul_rst/cnt", 32'(cnt), 32'd0);
        chk("mul_rst/ready", 32'(in_ready), 32'd1);
        #2 nrst = 1'b1;
        repeat (12) @(posedge step);
        #1;
        chk("mul_rst_late/out", 32'(out), 32'd0);
        chk("mul_rst_late/cnt", 32'(cnt), 32'd0);
        chk("mul_rst_late/ready", 32'(in_ready), 32'd1);
`else
        cmd("ipush_a", 1, NOP, 8'd1, 8'd1, 3'd1, 3'b000);
        cmd("ipush_b", 1, NOP, 8'd2, 8'd2, 3'd2, 3'b000);
        cmd("mul_ill", 0, MUL, 8'd0, 8'd2, 3'd2, 3'b001);
        err_clr = 1'b1;
        cmd("mul_ill_clr", 0, MUL, 8'd0, 8'd2, 3'd2, 3'b001);
        clr("ill0");
        cmd("add_after_ill", 0, ADD, 8'd0, 8'd3, 3'd1, 3'b000);
        #3 nrst = 1'b0;
        #1;
        chk("rst2/out", 32'(out), 32'd0);
        chk("rst2/cnt", 32'(cnt), 32'd0);
        #2 nrst = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
